// File: rtl/smd_pad_reader_pkg.sv
// Shared types and constants for the Mega Drive pad poller: FSM states,
// SEL slot numbering and bit positions in the published button word.
package smd_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Even slots drive SEL high, odd slots drive it low.
  localparam logic [2:0] SLOT_H0 = 3'd0;
  localparam logic [2:0] SLOT_L0 = 3'd1;
  localparam logic [2:0] SLOT_H1 = 3'd2;
  localparam logic [2:0] SLOT_L1 = 3'd3;
  localparam logic [2:0] SLOT_H2 = 3'd4;
  localparam logic [2:0] SLOT_L2 = 3'd5;
  localparam logic [2:0] SLOT_H3 = 3'd6;
  localparam logic [2:0] SLOT_L3 = 3'd7;

  localparam int BTN_UP = 0;
  localparam int BTN_DW = 1;
  localparam int BTN_LF = 2;
  localparam int BTN_RG = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_ST = 7;
  localparam int BTN_Z  = 8;
  localparam int BTN_Y  = 9;
  localparam int BTN_X  = 10;
  localparam int BTN_MD = 11;

endpackage

// File: rtl/smd_pad_reader_if.sv
// Pad-side and host-side signals of the poller, plus a debug view of its FSM.
interface smd_pad_reader_if;
  import smd_pad_pkg::*;

  // valid is a one-cycle strobe with no ready: buttons/pad_present/six_button
  // are stable between strobes, so a consumer may sample them at any time.
  logic        enable;
  logic [5:0]  p_in;
  logic        sel;
  logic [11:0] buttons;
  logic        pad_present;
  logic        six_button;
  logic        valid;
  logic        busy;
  state_e      dbg_state;

  modport master (
    input  enable, p_in,
    output sel, buttons, pad_present, six_button, valid, busy, dbg_state
  );

  modport slave (
    output enable, p_in,
    input  sel, buttons, pad_present, six_button, valid, busy, dbg_state
  );

endinterface

// File: rtl/smd_pad_reader_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle (released) pad pins read high.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/smd_pad_reader.sv
// Polls a 3/6-button Mega Drive pad through the 8-slot SEL sequence and
// publishes a frame-consistent active-high button word with presence flags.
module smd_pad_reader
  import smd_pad_pkg::*;
#(
  parameter int STEP_CYCLES = 20,
  parameter int POLL_CYCLES = 170000
) (
  input  logic              clk,
  input  logic              rst_n,
  smd_pad_reader_if.master  bus
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int TW = $clog2(POLL_CYCLES);
  localparam logic [SW-1:0] STEP_LAST    = SW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 1);

  state_e        r_state;
  logic [2:0]    r_slot;
  logic [SW-1:0] r_step;
  logic [TW-1:0] r_timer;
  logic          r_sel;
  logic          r_valid;

  logic [11:0]   r_cap_btn;
  logic          r_cap_present;
  logic          r_cap_six;
  logic [11:0]   r_buttons;
  logic          r_present;
  logic          r_six;

  logic [5:0]    w_p;
  logic          w_sample;

  sync2 #(.WIDTH(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.p_in),
    .o_q   (w_p)
  );

  assign w_sample = (r_state == ST_DRIVE) && (r_step == STEP_LAST);

  // The poll timer free-runs through DRIVE/DONE so the frame period is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_slot  <= SLOT_H0;
      r_step  <= '0;
      r_timer <= TIMER_RELOAD;
      r_sel   <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel <= 1'b1;
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (bus.enable) begin
            r_state <= ST_DRIVE;
            r_slot  <= SLOT_H0;
            r_step  <= '0;
            r_timer <= TIMER_RELOAD;
          end
        end
        ST_DRIVE: begin
          if (r_timer != '0) r_timer <= r_timer - 1'b1;
          if (r_step == STEP_LAST) begin
            r_step <= '0;
            if (r_slot == SLOT_L3) begin
              r_state <= ST_DONE;
              r_sel   <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_slot <= r_slot + 3'd1;
              // next slot is odd (SEL low) exactly when the current one is even
              r_sel  <= r_slot[0];
            end
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        ST_DONE: begin
          if (r_timer != '0) r_timer <= r_timer - 1'b1;
          r_state <= ST_IDLE;
          r_slot  <= SLOT_H0;
          r_sel   <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= 1'b1;
        end
      endcase
    end
  end

  // Shadow capture per slot; the published word is loaded at the end of L3
  // so it appears in the DONE cycle together with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_btn     <= '0;
      r_cap_present <= 1'b0;
      r_cap_six     <= 1'b0;
      r_buttons     <= '0;
      r_present     <= 1'b0;
      r_six         <= 1'b0;
    end else if (w_sample) begin
      case (r_slot)
        SLOT_H0: begin
          r_cap_btn[BTN_UP] <= ~w_p[5];
          r_cap_btn[BTN_DW] <= ~w_p[4];
          r_cap_btn[BTN_LF] <= ~w_p[3];
          r_cap_btn[BTN_RG] <= ~w_p[2];
          r_cap_btn[BTN_B]  <= ~w_p[1];
          r_cap_btn[BTN_C]  <= ~w_p[0];
          r_cap_btn[11:8]   <= 4'b0000;
        end
        SLOT_L0: begin
          r_cap_present     <= (w_p[3:2] == 2'b00);
          r_cap_btn[BTN_A]  <= ~w_p[1];
          r_cap_btn[BTN_ST] <= ~w_p[0];
        end
        SLOT_L2: begin
          r_cap_six <= (w_p[5:2] == 4'b0000);
        end
        SLOT_H3: begin
          if (r_cap_six) begin
            r_cap_btn[BTN_Z]  <= ~w_p[5];
            r_cap_btn[BTN_Y]  <= ~w_p[4];
            r_cap_btn[BTN_X]  <= ~w_p[3];
            r_cap_btn[BTN_MD] <= ~w_p[2];
          end
        end
        SLOT_L3: begin
          if (!r_cap_present) begin
            r_buttons <= '0;
            r_present <= 1'b0;
            r_six     <= 1'b0;
          end else begin
            r_present <= 1'b1;
            r_six     <= r_cap_six;
            r_buttons <= r_cap_six ? r_cap_btn : {4'b0000, r_cap_btn[7:0]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sel         = r_sel;
  assign bus.valid       = r_valid;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.buttons     = r_buttons;
  assign bus.pad_present = r_present;
  assign bus.six_button  = r_six;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_smd_pad_reader.sv
// Bench for smd_pad_reader: behavioural 3/6-button pad, table-driven frames,
// randomized frames, enable drop and mid-frame reset sequences.
module tb_smd_pad_reader;
  import smd_pad_pkg::*;

  localparam int STEP      = 6;
  localparam int POLL      = 8 * STEP + 9000;
  localparam int FRAME_LEN = 8 * STEP + 1;
  localparam int PAD_TIMEOUT = 1000;
  localparam int W = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  smd_pad_reader_if bus ();

  smd_pad_reader #(
    .STEP_CYCLES (STEP),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- pad model ----------------
  // mode 0: nothing plugged, 1: 3-button pad, 2: 6-button pad.
  int          pad_mode = 0;
  logic [11:0] pad_btn  = '0;
  logic        prev_sel = 1'b1;
  int          pad_edges = 0;
  int          hi_cnt = 0;

  always @(posedge clk) begin
    prev_sel <= bus.sel;
    if (bus.sel && !prev_sel) begin
      pad_edges <= pad_edges + 1;
      hi_cnt    <= 0;
    end else if (bus.sel) begin
      if (hi_cnt < PAD_TIMEOUT) hi_cnt <= hi_cnt + 1;
      else pad_edges <= 0;
    end
  end

  logic [5:0] pad_hi, pad_lo;
  always_comb begin
    pad_hi = ~{pad_btn[BTN_UP], pad_btn[BTN_DW], pad_btn[BTN_LF], pad_btn[BTN_RG], pad_btn[BTN_B], pad_btn[BTN_C]};
    pad_lo = {~pad_btn[BTN_UP], ~pad_btn[BTN_DW], 2'b00, ~pad_btn[BTN_A], ~pad_btn[BTN_ST]};
    bus.p_in = 6'h3F;
    if (pad_mode == 1) begin
      bus.p_in = bus.sel ? pad_hi : pad_lo;
    end else if (pad_mode == 2) begin
      if (bus.sel) begin
        if (pad_edges == 3)
          bus.p_in = {~pad_btn[BTN_Z], ~pad_btn[BTN_Y], ~pad_btn[BTN_X], ~pad_btn[BTN_MD], 2'b11};
        else
          bus.p_in = pad_hi;
      end else begin
        if (pad_edges == 2)      bus.p_in = {4'b0000, ~pad_btn[BTN_A], ~pad_btn[BTN_ST]};
        else if (pad_edges == 3) bus.p_in = {4'b1111, ~pad_btn[BTN_A], ~pad_btn[BTN_ST]};
        else                     bus.p_in = pad_lo;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int last_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {pad_present, six_button, buttons} from the pad type and held buttons.
  function automatic logic [W-1:0] ref_model(input int mode, input logic [11:0] btn);
    if (mode == 0) return '0;
    if (mode == 1) return {1'b1, 1'b0, 4'h0, btn[7:0]};
    return {1'b1, 1'b1, btn};
  endfunction

  task automatic rand_pad(output int mode, output logic [11:0] btn);
    mode = $urandom_range(0, 2);
    btn  = 12'($urandom_range(0, 4095));
    // a d-pad cannot press up and down together
    if (btn[BTN_UP] && btn[BTN_DW]) btn[BTN_DW] = 1'b0;
  endtask

  // ---------------- driver: one frame ----------------
  task automatic run_frame(input int mode, input logic [11:0] btn, input logic [W-1:0] exp_w,
                           input int wait_limit, input bit chk_period, input bit drop_en,
                           input int abort_k);
    int waited = 0;
    int idle_bad = 0;
    int sel_bad = 0;
    int busy_bad = 0;
    int t_start;
    logic exp_sel;
    pad_mode = mode;
    pad_btn  = btn;
    while (bus.busy !== 1'b1 && waited < wait_limit) begin
      @(negedge clk);
      waited++;
      if (bus.busy !== 1'b1 && (bus.sel !== 1'b1 || bus.valid !== 1'b0)) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    if (bus.busy !== 1'b1) begin
      check("frame_start_timeout", {31'd0, bus.busy}, 1);
      return;
    end
    t_start = cyc;
    if (chk_period) check("frame_period", t_start - last_start, POLL);
    last_start = t_start;
    if (abort_k < 0) exp_q.push_back(exp_w);
    for (int k = 0; k < FRAME_LEN - 1; k++) begin
      exp_sel = ((k / STEP) % 2) == 0;
      if (bus.sel !== exp_sel) sel_bad++;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0) busy_bad++;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {bus.sel, bus.busy, bus.valid, bus.six_button, bus.pad_present, bus.buttons},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_start = cyc;
        return;
      end
      if (drop_en && k == 3 * STEP) bus.enable = 1'b0;
      @(negedge clk);
    end
    check("sel_pattern", sel_bad, 0);
    check("busy_in_frame", busy_bad, 0);
    check("done_strobe", {bus.sel, bus.busy, bus.valid}, 3'b111);
    check("frame_result", {bus.pad_present, bus.six_button, bus.buttons}, exp_q.pop_front());
    @(negedge clk);
    check("valid_single", {bus.busy, bus.valid}, 2'b00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          mode;
    logic [11:0] btn;
    logic [11:0] exp_btn;
    logic        exp_present;
    logic        exp_six;
  } vec_t;
  vec_t vec[4];

  initial begin
    int          mode;
    logic [11:0] btn;
    int          quiet_bad;

    // 6-button: A + Start + Z
    vec[0] = '{2, 12'h190, 12'h190, 1'b1, 1'b1};
    // 3-button: up + C
    vec[1] = '{1, 12'h041, 12'h041, 1'b1, 1'b0};
    // nothing connected: pins float high
    vec[2] = '{0, 12'h5A5, 12'h000, 1'b0, 1'b0};
    // 3-button with X/Y held in the model: top nibble must stay clear
    vec[3] = '{1, 12'h620, 12'h020, 1'b1, 1'b0};

    bus.enable = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.sel, bus.busy, bus.valid, bus.six_button, bus.pad_present, bus.buttons},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    check("reset_state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    rst_n = 1'b1;
    last_start = cyc;

    for (int i = 0; i < 4; i++)
      run_frame(vec[i].mode, vec[i].btn, {vec[i].exp_present, vec[i].exp_six, vec[i].exp_btn},
                POLL + 5, 1'b1, 1'b0, -1);

    // enable dropped in L1: this frame still commits, then the block idles
    btn = 12'($urandom_range(1, 4095));
    run_frame(2, btn, ref_model(2, btn), POLL + 5, 1'b1, 1'b1, -1);
    quiet_bad = 0;
    for (int i = 0; i < POLL + 50; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.sel !== 1'b1 || bus.valid !== 1'b0) quiet_bad++;
    end
    check("enable_low_quiet", quiet_bad, 0);

    // enable returns: frame starts at once, then reset lands in H2
    bus.enable = 1'b1;
    rand_pad(mode, btn);
    run_frame(mode, btn, ref_model(mode, btn), 1, 1'b0, 1'b0, 4 * STEP + 2);

    // randomized frames after the reset release
    for (int i = 0; i < 2; i++) begin
      rand_pad(mode, btn);
      run_frame(mode, btn, ref_model(mode, btn), POLL + 5, 1'b1, 1'b0, -1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
